// File: rtl/cpu_fwd_hazard_unit.sv
// Operand forwarding selection and scoreboard-based RAW hazard detection.
// Per-register busy counters track in-flight multi-cycle producers.
module cpu_fwd_hazard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int REG_WIDTH    = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_FWD      = 2,
  parameter int MAX_LAT      = 7,
  parameter int CNTW         = 16,
  localparam int RIDX = $clog2(NUM_REGS),
  localparam int SELW = $clog2(NUM_FWD + 1),
  localparam int LATW = $clog2(MAX_LAT + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD_PORTS*RIDX-1:0]      rs_id,
  input  logic [NUM_RD_PORTS-1:0]           rs_valid,
  input  logic [NUM_FWD*RIDX-1:0]           fwd_rd,
  input  logic [NUM_FWD-1:0]                fwd_we,
  input  logic [NUM_FWD*REG_WIDTH-1:0]      fwd_value,
  input  logic                              issue_valid,
  input  logic [RIDX-1:0]                   issue_rd,
  input  logic [LATW-1:0]                   issue_lat,
  input  logic                              flush,
  output logic [NUM_RD_PORTS*SELW-1:0]      bypass_sel,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0] bypass_value,
  output logic                              stall,
  output logic [CNTW-1:0]                   stall_count
);

  logic [LATW-1:0]     busy_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nz;
  logic [NUM_REGS-1:0] issue_hit;
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic [LATW-1:0]     lat_clamped;
  logic                accept;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_nz[i] = (busy_reg[i] != '0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
      logic [RIDX-1:0]      rs;
      logic [SELW-1:0]      sel;
      logic [REG_WIDTH-1:0] val;

      assign rs = rs_id[gi*RIDX +: RIDX];
      assign port_stall[gi] = rs_valid[gi] && (rs != '0) && busy_nz[rs];

      // Walk from oldest to youngest so the youngest matching stage wins.
      always_comb begin
        sel = '0;
        val = '0;
        if (rs_valid[gi] && (rs != '0)) begin
          for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] && (fwd_rd[k*RIDX +: RIDX] == rs)) begin
              sel = SELW'(k + 1);
              val = fwd_value[k*REG_WIDTH +: REG_WIDTH];
            end
          end
        end
      end

      assign bypass_sel[gi*SELW +: SELW]           = sel;
      assign bypass_value[gi*REG_WIDTH +: REG_WIDTH] = val;
    end
  endgenerate

  assign stall       = |port_stall;
  assign accept      = issue_valid && !stall && !flush;
  assign lat_clamped = (issue_lat > LATW'(MAX_LAT)) ? LATW'(MAX_LAT) : issue_lat;
  assign issue_hit   = (accept && (lat_clamped != '0)) ? (NUM_REGS'(1) << issue_rd) : '0;

  // Register 0 is hardwired and never tracked; a new producer overrides any count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        busy_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0 || flush) begin
          busy_reg[i] <= '0;
        end else if (issue_hit[i]) begin
          busy_reg[i] <= lat_clamped;
        end else if (busy_nz[i]) begin
          busy_reg[i] <= busy_reg[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_fwd_hazard_unit.sv
// Directed bench for cpu_fwd_hazard_unit: expected values are queued with the
// stimulus and popped/compared at the following falling clock edge.
module tb_cpu_fwd_hazard_unit;

  localparam int RIDX = 5;
  localparam int SELW = 2;
  localparam int LATW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rs_id;
  logic [1:0]  rs_valid;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_we;
  logic [63:0] fwd_value;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic        flush;
  logic [3:0]  bypass_sel;
  logic [63:0] bypass_value;
  logic        stall;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  cpu_fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_valid(rs_valid),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_value(fwd_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .bypass_sel(bypass_sel), .bypass_value(bypass_value),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int which);
    case (which)
      0:       return 64'(stall);
      1:       return 64'(stall_count);
      2:       return 64'(bypass_sel[SELW-1:0]);
      3:       return 64'(bypass_value[31:0]);
      4:       return 64'(bypass_sel[2*SELW-1:SELW]);
      default: return 64'(bypass_value[63:32]);
    endcase
  endfunction

  task automatic push(input string tag, input int which, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.which = which; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.which), e.exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    compare_now();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rs_id = '0; rs_valid = '0; fwd_rd = '0; fwd_we = '0;
    fwd_value = '0; issue_valid = 1'b0; issue_rd = '0; issue_lat = '0; flush = 1'b0;
    #1;
    push("rst_stall", 0, 0); push("rst_count", 1, 0);
    drain();
    #2 rst_n = 1'b1;
    tick();

    // Forward priority: youngest stage wins.
    fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_value = {32'hBBBB, 32'hAAAA};
    rs_id = {5'd0, 5'd5}; rs_valid = 2'b01;
    push("fwd_sel_both", 2, 1); push("fwd_val_both", 3, 64'hAAAA); push("fwd_stall", 0, 0);
    drain();
    fwd_we = 2'b10;
    push("fwd_sel_s1", 2, 2); push("fwd_val_s1", 3, 64'hBBBB);
    drain();
    rs_valid = 2'b00;
    push("fwd_sel_inv", 2, 0); push("fwd_val_inv", 3, 0);
    drain();
    fwd_we = 2'b00;

    // Load-use with lat 2; issues offered during the stall are dropped.
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_lat = 3'd2;
    push("lu_pre_stall", 0, 0);
    drain();
    tick();
    issue_rd = 5'd4; issue_lat = 3'd6;
    rs_id = {5'd0, 5'd7}; rs_valid = 2'b01;
    push("lu_stall1", 0, 1); push("lu_count1", 1, 0);
    drain();
    tick();
    push("lu_stall2", 0, 1); push("lu_count2", 1, 1);
    drain();
    tick();
    issue_valid = 1'b0;
    rs_id = {5'd4, 5'd7}; rs_valid = 2'b11;
    push("lu_release", 0, 0); push("lu_count_end", 1, 2);
    drain();

    // WAW: second producer to r3 overrides the longer latency.
    tick();
    rs_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd3; issue_lat = 3'd5;
    tick();
    issue_lat = 3'd1;
    tick();
    issue_valid = 1'b0;
    rs_id = {5'd0, 5'd3}; rs_valid = 2'b01;
    push("waw_stall", 0, 1); push("waw_count", 1, 2);
    drain();
    tick();
    push("waw_release", 0, 0); push("waw_count_end", 1, 3);
    drain();

    // x0 is never busy and never forwarded.
    tick();
    rs_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd0; issue_lat = 3'd4;
    tick();
    issue_valid = 1'b0;
    rs_id = '0; rs_valid = 2'b01;
    fwd_rd = '0; fwd_we = 2'b01; fwd_value = {32'h1111, 32'h2222};
    push("x0_stall", 0, 0); push("x0_sel", 2, 0); push("x0_val", 3, 0);
    drain();
    fwd_we = 2'b00;

    // Flush during a stall on port 1.
    tick();
    rs_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
    tick();
    issue_valid = 1'b0;
    rs_id = {5'd9, 5'd0}; rs_valid = 2'b10;
    fwd_we = 2'b10; fwd_rd = {5'd9, 5'd0}; fwd_value = {32'hBBBB, 32'hAAAA};
    flush = 1'b1;
    push("fl_stall", 0, 1); push("fl_count", 1, 3);
    push("fl_sel1", 4, 2); push("fl_val1", 5, 64'hBBBB);
    drain();
    tick();
    flush = 1'b0; fwd_we = 2'b00;
    push("fl_release", 0, 0); push("fl_count_after", 1, 3);
    drain();

    // Asynchronous reset in the middle of a stall.
    tick();
    rs_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd4;
    tick();
    issue_valid = 1'b0;
    rs_id = {5'd0, 5'd9}; rs_valid = 2'b01;
    push("ar_stall_a", 0, 1); push("ar_count_a", 1, 3);
    drain();
    tick();
    push("ar_stall_b", 0, 1); push("ar_count_b", 1, 4);
    drain();
    #2 rst_n = 1'b0;
    #1;
    push("ar_stall_now", 0, 0); push("ar_count_now", 1, 0);
    compare_now();
    tick();
    #2 rst_n = 1'b1;
    tick();
    push("ar_after_stall", 0, 0); push("ar_after_count", 1, 0);
    drain();

    // Normal operation resumes after reset.
    tick();
    rs_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd1;
    tick();
    issue_valid = 1'b0; rs_valid = 2'b01;
    push("rs_stall", 0, 1); push("rs_count", 1, 0);
    drain();
    tick();
    push("rs_release", 0, 0); push("rs_count_end", 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fwd_hazard_unit.md
CPU_FWD_HAZARD_UNIT -- requirements
Module: cpu_fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning architectural register count; RIDX = clog2(NUM_REGS).
REQ-002 SHALL have parameter REG_WIDTH, default 32, meaning datapath width.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, meaning source operand ports checked per cycle.
REQ-004 SHALL have parameter NUM_FWD, default 2, meaning forwarding stages (index 0 = youngest); SELW = clog2(NUM_FWD+1).
REQ-005 SHALL have parameter MAX_LAT, default 7, meaning maximum producer latency; LATW = clog2(MAX_LAT+1).
REQ-006 SHALL have parameter CNTW, default 16, meaning stall-counter width.
REQ-007 SHALL use one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-008 SHALL have rs_id, input, NUM_RD_PORTS*RIDX: source register per port.
REQ-009 SHALL have rs_valid, input, NUM_RD_PORTS: port uses its operand.
REQ-010 SHALL have fwd_rd, input, NUM_FWD*RIDX: destination register per stage.
REQ-011 SHALL have fwd_we, input, NUM_FWD: stage will write back.
REQ-012 SHALL have fwd_value, input, NUM_FWD*REG_WIDTH: result per stage.
REQ-013 SHALL have issue_valid, input, 1: instruction leaving decode.
REQ-014 SHALL have issue_rd, input, RIDX: its destination.
REQ-015 SHALL have issue_lat, input, LATW: cycles until its result reaches stage 0 (0 = single-cycle, not tracked).
REQ-016 SHALL have flush, input, 1: pipeline flush.
REQ-017 SHALL have bypass_sel, output, NUM_RD_PORTS*SELW: 0 = register file, k = stage k-1.
REQ-018 SHALL have bypass_value, output, NUM_RD_PORTS*REG_WIDTH: selected forwarded value (0 when sel = 0).
REQ-019 SHALL have stall, output, 1: hold decode this cycle.
REQ-020 SHALL have stall_count, output, CNTW: saturating count of stalled cycles.

Function
REQ-021 SHALL keep a scoreboard counter busy[r] (LATW bits) for every register r; busy[0] is always 0.
REQ-022 SHALL drive bypass_sel/bypass_value combinationally: per port, the lowest stage index k with fwd_we[k]=1 and fwd_rd[k]=rs_id gives sel = k+1; no match, rs_id = 0 or rs_valid = 0 gives sel = 0.
REQ-023 SHALL assert stall combinationally when any port has rs_valid=1, rs_id!=0 and busy[rs_id]!=0.
REQ-024 SHALL accept an issue when issue_valid=1, stall=0 and flush=0; an accepted issue with issue_lat>0 and issue_rd!=0 loads busy[issue_rd] <= issue_lat at the next edge, overriding any decrement or previous count (WAW: the latest producer wins).
REQ-025 SHALL decrement every other nonzero busy[r] by 1 per cycle, saturating at 0.
REQ-026 SHALL ignore issue_valid while stall=1; the requester retries.
REQ-027 SHALL clear all busy[] at the next edge when flush=1, with priority over issue and decrement; stall_count is unaffected.
REQ-028 SHALL clamp an issue_lat > MAX_LAT to MAX_LAT.
REQ-029 SHALL increment stall_count on every edge where stall=1 and flush=0, saturating at all-ones.
REQ-030 SHALL give a producer with issue_lat=L issued at edge t a release of stall for dependents in the cycle after edge t+L, with its value then available via forwarding stage 0.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronously), hold all busy[]=0 and stall_count=0; stall is therefore 0, and bypass outputs follow the REQ-022 inputs.
REQ-032 SHALL resume normal operation at the first rising clk edge after rst_n deasserts; reset mid-stall drops stall immediately.

Verification
REQ-033 SHALL pass a forward-priority test: fwd_we=2'b11, fwd_rd={5,5}, fwd_value={0xBBBB,0xAAAA}, rs_id[0]=5 -> bypass_sel[0]=1, bypass_value[0]=0xAAAA.
REQ-034 SHALL pass a load-use test: issue rd=7, lat=2, then rs_id[0]=7 valid -> stall=1 for exactly 2 cycles, stall_count=2, then stall=0.
REQ-035 SHALL pass a WAW-override test: issue rd=3, lat=5, then next cycle issue rd=3, lat=1 -> busy[3]=1, and a dependent stalls for 1 cycle only.
REQ-036 SHALL pass an x0 test: issue rd=0, lat=4, then rs_id=0 -> stall=0, bypass_sel=0, even with fwd_rd=0 and fwd_we=1.
REQ-037 SHALL pass a flush-during-stall test: busy[9]=3, stall on port 1, then flush=1 for one cycle -> stall=0 the next cycle, with stall_count unchanged by the flush cycle.
REQ-038 SHALL pass an async-reset test: rst_n low mid-stall, between clock edges -> stall=0 and stall_count=0 immediately, without waiting for clk.
